// File: rtl/amul_share_ctrl_if.sv
// amul_share_ctrl_if
//   Bundles the requester, multiplier and response channels of the shared
//   approximate multiplier controller.
//   Ports (signals):
//     req_valid/req_ready [NREQ]   per-requester handshake
//     req_x/req_y [NREQ][32]       requester operands (lane i = bits 32i+31:32i)
//     mul_x/mul_y [32]             registered operands to the multiplier
//     mul_z [64]                   product from the multiplier
//     rsp_valid/rsp_ready          response handshake
//     rsp_id [clog2(NREQ)]         owner of rsp_z
//     rsp_z [64]                   captured product
//   Modports: slave = controller side, master = requesters/multiplier side.
interface amul_share_ctrl_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0][31:0] req_x;
    logic [NREQ-1:0][31:0] req_y;
    logic [31:0]           mul_x;
    logic [31:0]           mul_y;
    logic [63:0]           mul_z;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [63:0]           rsp_z;

    modport slave (
        input  req_valid, req_x, req_y, mul_z, rsp_ready,
        output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_z
    );

    modport master (
        output req_valid, req_x, req_y, mul_z, rsp_ready,
        input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_z
    );
endinterface

// File: rtl/amul_share_ctrl.sv
// amul_share_ctrl
//   Shares one combinational approximate 32x32 multiplier among NREQ
//   requesters. Round-robin grant in IDLE, operands latched onto mul_x/mul_y
//   on accept, product captured LAT cycles later and held on the response
//   channel until accepted. One transaction in flight at a time.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        amul_share_ctrl_if.slave (request / multiplier / response)
//     grant_cnt  [NREQ*16] per-requester accept counters (only with
//                AMUL_SHARE_STATS_EN defined)
//   Build option: `define AMUL_SHARE_STATS_EN adds the grant_cnt output.
module amul_share_ctrl #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    amul_share_ctrl_if.slave      bus
`ifdef AMUL_SHARE_STATS_EN
    ,
    output logic [NREQ*16-1:0]    grant_cnt
`endif
);
    localparam int IDW = $clog2(NREQ);
    // Counter holds LAT-1; keep at least one bit for LAT == 1.
    localparam int CW  = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  cur_id;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     mul_x_q, mul_y_q;
    logic [63:0]     rsp_z_q;
    logic [IDW-1:0]  rsp_id_q;

    logic [IDW-1:0]  grant_id;
    logic            grant_vld;
    logic [NREQ-1:0] req_ready;
    logic            rsp_valid;
    logic            accept;
    logic            rsp_hs;
    logic            wait_done;

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ. The sum is
    // one bit wider than an index so it can be folded back without overflow.
    always_comb begin
        logic [IDW:0] sum;
        grant_vld = 1'b0;
        grant_id  = '0;
        sum       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            if (!grant_vld && bus.req_valid[sum[IDW-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = sum[IDW-1:0];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign wait_done = (wait_cnt == '0);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = WAIT;
            WAIT:    if (wait_done) state_nxt = RESP;
            RESP:    if (rsp_hs)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. Grant is suppressed while rst is high so nothing can be
    // handshaked during reset.
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    if (grant_vld && !rst) req_ready[grant_id] = 1'b1;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign accept = |(bus.req_valid & req_ready);
    assign rsp_hs = rsp_valid & bus.rsp_ready;

    // Operand launch, latency counter, product capture and pointer update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_x_q  <= '0;
            mul_y_q  <= '0;
            cur_id   <= '0;
            wait_cnt <= '0;
            rsp_z_q  <= '0;
            rsp_id_q <= '0;
            rr_ptr   <= '0;
        end else begin
            if (accept) begin
                mul_x_q  <= bus.req_x[grant_id];
                mul_y_q  <= bus.req_y[grant_id];
                cur_id   <= grant_id;
                wait_cnt <= CW'(LAT - 1);
            end else if (state == WAIT && !wait_done) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == WAIT && wait_done) begin
                rsp_z_q  <= bus.mul_z;
                rsp_id_q <= cur_id;
            end
            if (rsp_hs)
                rr_ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.mul_x     = mul_x_q;
    assign bus.mul_y     = mul_y_q;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_z     = rsp_z_q;

`ifdef AMUL_SHARE_STATS_EN
    // One wrapping 16-bit accept counter per requester.
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
        logic [15:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)                                 cnt <= '0;
            else if (accept && grant_id == IDW'(i))  cnt <= cnt + 16'd1;
        end
        assign grant_cnt[16*i +: 16] = cnt;
    end
`endif
endmodule

// File: doc/amul_share_ctrl.md
# amul_share_ctrl

Sequential controller that shares one combinational approximate 32x32 unsigned multiplier (truncated-operand type, 64-bit product) among NREQ requesters. It performs round-robin arbitration, latches the winner's operands onto the multiplier inputs, waits a fixed settle latency, captures the product and returns it with the requester ID over a valid/ready response channel. It sits between the accelerator's MAC issue ports and the single approximate multiplier instance. Only one transaction is in flight at a time.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 2, cycles from operand launch to product capture (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept, at most one bit high
- req_x  in  NREQ*32  operand x, requester i at bits [32i+31:32i]
- req_y  in  NREQ*32  operand y, same packing
- mul_x  out  32  registered operand x to multiplier
- mul_y  out  32  registered operand y to multiplier
- mul_z  in  64  product from multiplier
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  clog2(NREQ)  index of requester owning rsp_z
- rsp_z  out  64  captured product

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: grant = first i with req_valid[i], searching from rr_ptr upward, modulo NREQ. req_ready[grant] = 1 combinationally, all others 0. If no req_valid, stay in IDLE, req_ready = 0.
- Accept (req_valid[g] & req_ready[g]): register req_x/req_y of g into mul_x/mul_y, store g as cur_id, load wait counter with LAT-1, go to WAIT.
- WAIT: req_ready = 0. Counter decrements each cycle; at 0, capture mul_z into rsp_z and cur_id into rsp_id, go to RESP.
- RESP: rsp_valid = 1, rsp_z/rsp_id held stable until rsp_ready. On handshake: rr_ptr = (cur_id+1) mod NREQ, go to IDLE.
- mul_x/mul_y hold last operands until next accept; no arithmetic is done in this block, mul_z passes through unmodified, 64 bits.
- Requesters deasserting req_valid while not granted: ignored, no state change.
- Requester data sampled only on accept cycle; later changes do not affect the in-flight product.

## Timing
- Reset values: state IDLE, rr_ptr 0, mul_x 0, mul_y 0, rsp_valid 0, rsp_id 0, rsp_z 0, req_ready 0 (no grant while rst high), counters 0.
- Accept in cycle T -> mul_x/mul_y valid from cycle T+1 -> mul_z sampled at the edge ending cycle T+LAT -> rsp_valid high from cycle T+LAT+1.
- Response handshake in cycle R -> IDLE in R+1; next accept earliest in R+1. Throughput with rsp_ready tied high: one product per LAT+2 cycles.
- rsp_valid, once high, never drops before rsp_ready.
- Async reset mid-transaction: in-flight product discarded, all outputs return to reset values immediately, no response issued.

## Configuration
- Macro AMUL_SHARE_STATS_EN.
- Defined: adds output grant_cnt (NREQ*16 bits), one 16-bit counter per requester, incremented on each accept of that requester, wraps 0xFFFF -> 0x0000, reset to 0.
- Undefined: port and counters absent; all other behaviour identical.

## Test plan
- Single request: req_valid[2]=1, x=0x0000_0400, y=0x0000_0003, mul_z model returns 0xC00 -> req_ready[2] high in cycle T, rsp_valid in T+LAT+1 with rsp_id=2, rsp_z=0x0000_0000_0000_0C00.
- Fairness: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1 with one accept every LAT+2 cycles.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_z/rsp_id stable, req_ready all 0, no new accept until handshake.
- Operand isolation: change req_x[1] from 0xFFFF_FFFF to 0 one cycle after accept -> mul_x stays 0xFFFF_FFFF, rsp_z equals product of original operands.
- Reset mid-WAIT: assert rst in WAIT -> rsp_valid 0, mul_x/mul_y 0, rr_ptr 0 same cycle; after release, requester 0 granted first when all valid.
- With AMUL_SHARE_STATS_EN: 3 accepts for requester 1, 1 for requester 3 -> grant_cnt slices = 0,3,0,1; 65536 accepts on requester 0 wraps its slice to 0.
